// File: rtl/long_string_renderer.sv
// Banner string renderer: fetches one 72-bit glyph row per scanline
// and shifts it out MSB-first as a raster-aligned pixel mask.
module long_string_renderer #(
    parameter int ORIGIN_X = 16,
    parameter int ORIGIN_Y = 16,
    parameter int SCALE    = 1
) (
    input  logic        VGA_CLK,
    input  logic        Reset,
    input  logic [10:0] H_Count,
    input  logic [10:0] V_Count,
    input  logic        Display_Enable,
    input  logic        String_Select,
    output logic [4:0]  String_Address,
    input  logic [71:0] String_Data,
    output logic        Pixel_On,
    output logic        Busy,
    output logic        Row_Done
);

    localparam logic [10:0] TRIG_X   = 11'(ORIGIN_X - 4);
    localparam logic [10:0] START_X  = 11'(ORIGIN_X);
    localparam logic [10:0] Y_LO     = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI     = 11'(ORIGIN_Y + 16 * SCALE);
    localparam logic [7:0]  COL_LAST = 8'(72 * SCALE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ARMED,
        DRAW
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic [71:0] shift_q, shift_d;
    logic [7:0]  col_q, col_d;
    logic        pixel_q, pixel_d;
    logic        done_q, done_d;

    logic        line_active;
    logic [10:0] v_off;
    logic [3:0]  row;
    logic [4:0]  fetch_addr;

    always_comb begin
        line_active = (V_Count >= Y_LO) && (V_Count < Y_HI);
        v_off       = V_Count - Y_LO;
        row         = 4'(v_off >> (SCALE - 1));
        fetch_addr  = String_Select ? (5'd17 + {1'b0, row}) : {1'b0, row};
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        col_d   = col_q;
        pixel_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (H_Count == TRIG_X && line_active && Display_Enable) begin
                    state_d = FETCH;
                    addr_d  = fetch_addr;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                state_d = ARMED;
                shift_d = String_Data;
            end
            ARMED: begin
                if (H_Count == START_X) begin
                    state_d = DRAW;
                    pixel_d = shift_q[71];
                    col_d   = 8'd0;
                    if (SCALE == 1) shift_d = shift_q << 1;
                end
            end
            DRAW: begin
                if (col_q == COL_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    col_d   = col_q + 8'd1;
                    pixel_d = shift_q[71];
                    // advance once the current bit has been held SCALE cycles
                    if (SCALE == 1 || col_d[0]) shift_d = shift_q << 1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !Display_Enable) begin
            state_d = IDLE;
            pixel_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= 5'd0;
            shift_q <= 72'd0;
            col_q   <= 8'd0;
            pixel_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            col_q   <= col_d;
            pixel_q <= pixel_d;
            done_q  <= done_d;
        end
    end

    assign String_Address = addr_q;
    assign Pixel_On       = pixel_q;
    assign Row_Done       = done_q;
    assign Busy           = (state_q != IDLE);

endmodule

// File: tb/tb_long_string_renderer.sv
// Directed raster sweeps for long_string_renderer at SCALE=1 and SCALE=2,
// each DUT fed by its own registered glyph ROM.
module tb_long_string_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h, v;
    logic        de, sel;
    logic [4:0]  a1, a2;
    logic [71:0] d1, d2;
    logic        p1, p2, b1, b2, r1, r2;

    int checks = 0;
    int failures = 0;

    bit          live [2];
    logic [4:0]  eaddr [2];
    logic [71:0] pat [2];

    always #5 clk = ~clk;

    long_string_renderer #(.ORIGIN_X(16), .ORIGIN_Y(16), .SCALE(1)) dut1 (
        .VGA_CLK(clk), .Reset(rst), .H_Count(h), .V_Count(v),
        .Display_Enable(de), .String_Select(sel), .String_Address(a1),
        .String_Data(d1), .Pixel_On(p1), .Busy(b1), .Row_Done(r1)
    );

    long_string_renderer #(.ORIGIN_X(16), .ORIGIN_Y(16), .SCALE(2)) dut2 (
        .VGA_CLK(clk), .Reset(rst), .H_Count(h), .V_Count(v),
        .Display_Enable(de), .String_Select(sel), .String_Address(a2),
        .String_Data(d2), .Pixel_On(p2), .Busy(b2), .Row_Done(r2)
    );

    function automatic logic [71:0] rom_row(input logic [4:0] a);
        if (a == 5'd2)  return 72'h7C1_000_000_000_000_000;
        if (a == 5'd20) return 72'hC30_000_000_000_000_000;
        return {a, 3'b110, 64'h5A3C_9617_E248_0DB3 ^ {59'd0, a}};
    endfunction

    always_ff @(posedge clk) begin
        d1 <= rom_row(a1);
        d2 <= rom_row(a2);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input int vv, input bit sel0, input int tog_h,
                         input int de_h, input int rst_h);
        int s, span, r, idx;
        bit win, erd, epix;
        for (int hh = 0; hh <= 170; hh++) begin
            h   = 11'(hh);
            v   = 11'(vv);
            de  = (hh != de_h);
            rst = (hh == rst_h);
            sel = (tog_h >= 0 && hh >= tog_h) ? !sel0 : sel0;
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                s    = d + 1;
                span = 72 * s;
                win  = (vv >= 16) && (vv < 16 + 16 * s);
                erd  = 1'b0;
                if (rst) begin
                    live[d]  = 1'b0;
                    eaddr[d] = 5'd0;
                end else if (!live[d] && hh == 12 && win && de) begin
                    r        = (vv - 16) >> (s - 1);
                    eaddr[d] = sel ? 5'(17 + r) : 5'(r);
                    pat[d]   = rom_row(eaddr[d]);
                    live[d]  = 1'b1;
                end else if (live[d] && !de) begin
                    live[d] = 1'b0;
                end else if (live[d] && hh == 16 + span) begin
                    erd     = 1'b1;
                    live[d] = 1'b0;
                end
                epix = 1'b0;
                if (live[d] && hh >= 16 && hh < 16 + span) begin
                    idx  = 71 - ((hh - 16) >> (s - 1));
                    epix = pat[d][idx];
                end
                chk($sformatf("pix s%0d v%0d h%0d", s, vv, hh),
                    32'(d == 0 ? p1 : p2), 32'(epix));
                chk($sformatf("busy s%0d v%0d h%0d", s, vv, hh),
                    32'(d == 0 ? b1 : b2), 32'(live[d]));
                chk($sformatf("done s%0d v%0d h%0d", s, vv, hh),
                    32'(d == 0 ? r1 : r2), 32'(erd));
                chk($sformatf("addr s%0d v%0d h%0d", s, vv, hh),
                    32'(d == 0 ? a1 : a2), 32'(eaddr[d]));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        h   = 11'd0;
        v   = 11'd0;
        de  = 1'b1;
        sel = 1'b0;
        for (int d = 0; d < 2; d++) begin
            live[d]  = 1'b0;
            eaddr[d] = 5'd0;
            pat[d]   = 72'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst pix1", 32'(p1), 32'd0);
        chk("rst busy1", 32'(b1), 32'd0);
        chk("rst done1", 32'(r1), 32'd0);
        chk("rst addr1", 32'(a1), 32'd0);
        chk("rst pix2", 32'(p2), 32'd0);
        chk("rst busy2", 32'(b2), 32'd0);
        chk("rst done2", 32'(r2), 32'd0);
        chk("rst addr2", 32'(a2), 32'd0);
        rst = 1'b0;

        sweep(18, 1'b0, -1, -1, -1);
        sweep(19, 1'b1, -1, -1, -1);
        sweep(20, 1'b0, -1, -1, -1);
        sweep(21, 1'b0, -1, -1, -1);
        sweep(15, 1'b0, -1, -1, -1);
        sweep(32, 1'b0, -1, -1, -1);
        sweep(18, 1'b0, -1, 30, -1);
        sweep(18, 1'b0, -1, -1, 30);
        sweep(18, 1'b0, 20, -1, -1);
        sweep(19, 1'b1, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
